// File: rtl/cycle_terminator_pkg.sv
// Shared decode header for the bus cycle terminator: device and port-width
// decode values, DSACK encodings, default timing constants and FSM encoding.
package cycle_terminator_pkg;

  localparam int DEVICE_SELECTED_MAXPOS = 10;
  localparam int PORT_WIDTH_WIDTH       = 2;

  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_NULL       = 10'h000;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_ROM        = 10'h001;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_SIMM       = 10'h002;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_REGISTER8  = 10'h004;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_REGISTER16 = 10'h008;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_REGISTER32 = 10'h010;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_QUART      = 10'h020;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_SLOT1      = 10'h040;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_SLOT2      = 10'h080;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_IDE        = 10'h100;
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_ETH        = 10'h200;

  // Devices that end their own cycles through slot_ack
  localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_EXT_MASK =
    DEVICE_SLOT1 | DEVICE_SLOT2 | DEVICE_IDE | DEVICE_ETH;

  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_NULL = 2'b00;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_BYTE = 2'b01;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_WORD = 2'b10;
  localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_LONG = 2'b11;

  localparam logic [1:0] DSACK_NONE = 2'b00;
  localparam logic [1:0] DSACK_BYTE = 2'b01;
  localparam logic [1:0] DSACK_WORD = 2'b10;
  localparam logic [1:0] DSACK_LONG = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_WAIT_ROM       = 3;
  localparam int DEFAULT_WAIT_SIMM      = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    EXTWAIT = 3'd2,
    ACK     = 3'd3,
    ERR     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLASS_NULL  = 2'd0,
    CLASS_FIXED = 2'd1,
    CLASS_EXT   = 2'd2
  } dev_class_t;

  function automatic dev_class_t device_class(input logic [DEVICE_SELECTED_MAXPOS-1:0] dev);
    if (dev == DEVICE_NULL) return CLASS_NULL;
    if ((dev & DEVICE_EXT_MASK) != DEVICE_NULL) return CLASS_EXT;
    return CLASS_FIXED;
  endfunction

  function automatic logic [1:0] dsack_for(input logic [PORT_WIDTH_WIDTH-1:0] pw);
    case (pw)
      PORT_WIDTH_BYTE: return DSACK_BYTE;
      PORT_WIDTH_WORD: return DSACK_WORD;
      PORT_WIDTH_LONG: return DSACK_LONG;
      default:         return DSACK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cycle_terminator_watchdog.sv
// Bus watchdog: counts edges while run is high and flags the timeout edge.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Restarts from zero whenever run drops, so every new cycle begins fresh
  always_ff @(posedge clock) begin
    if (!reset_n || !run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cycle_terminator.sv
// Bus cycle terminator: answers each address-strobe cycle with DSACK after the
// device's wait states or an external slot_ack, or with BERR on decode/timeout.
module cycle_terminator
  import cycle_terminator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int WAIT_ROM       = DEFAULT_WAIT_ROM,
  parameter int WAIT_SIMM      = DEFAULT_WAIT_SIMM
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              as,
  input  logic                              function_normal_selected,
  input  logic [DEVICE_SELECTED_MAXPOS-1:0] device_selected,
  input  logic [PORT_WIDTH_WIDTH-1:0]       port_width,
  input  logic                              slot_ack,
  output logic [1:0]                        dsack,
  output logic                              berr
);

  state_t                      state, state_next;
  logic [7:0]                  wait_count, wait_count_next, wait_states;
  logic [PORT_WIDTH_WIDTH-1:0] pw_q, pw_next;
  logic                        no_term, no_term_next;
  logic                        terminate;
  logic                        run, expired;
  dev_class_t                  dev_class;

  assign dev_class = device_class(device_selected);
  assign run       = (state == WAIT) || (state == EXTWAIT);

  always_comb begin
    wait_states = 8'd0;
    if ((device_selected & DEVICE_ROM) != DEVICE_NULL) begin
      wait_states = 8'(WAIT_ROM);
    end else if ((device_selected & DEVICE_SIMM) != DEVICE_NULL) begin
      wait_states = 8'(WAIT_SIMM);
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .expired (expired)
  );

  // Non-normal cycles (FPU, interrupt acknowledge) park in EXTWAIT with
  // terminations masked so only the watchdog can end them.
  always_comb begin
    state_next      = state;
    wait_count_next = wait_count;
    pw_next         = pw_q;
    no_term_next    = no_term;
    terminate       = 1'b0;
    unique case (state)
      IDLE: begin
        if (as) begin
          pw_next         = port_width;
          no_term_next    = !function_normal_selected;
          wait_count_next = wait_states;
          if (!function_normal_selected) begin
            state_next = EXTWAIT;
          end else begin
            case (dev_class)
              CLASS_NULL: state_next = ERR;
              CLASS_EXT:  state_next = EXTWAIT;
              default:    state_next = WAIT;
            endcase
          end
        end
      end
      WAIT: begin
        if (!as) begin
          state_next = IDLE;
        end else if (wait_count == 8'd0) begin
          terminate = 1'b1;
        end else begin
          wait_count_next = wait_count - 8'd1;
        end
      end
      EXTWAIT: begin
        if (!as) begin
          state_next = IDLE;
        end else begin
          terminate = slot_ack && !no_term;
        end
      end
      ACK, ERR: begin
        if (!as) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Termination beats a simultaneous timeout
    if (run && as) begin
      if (terminate) begin
        state_next = (pw_q == PORT_WIDTH_NULL) ? ERR : ACK;
      end else if (expired) begin
        state_next = ERR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_count <= 8'd0;
      pw_q       <= PORT_WIDTH_NULL;
      no_term    <= 1'b0;
      dsack      <= DSACK_NONE;
      berr       <= 1'b0;
    end else begin
      state      <= state_next;
      wait_count <= wait_count_next;
      pw_q       <= pw_next;
      no_term    <= no_term_next;
      dsack      <= (state_next == ACK) ? dsack_for(pw_q) : DSACK_NONE;
      berr       <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_cycle_terminator.sv
// Directed and randomized checks of cycle_terminator against a cycle-level
// model that tracks edges since cycle start rather than FSM states.
module tb_cycle_terminator;
  import cycle_terminator_pkg::*;

  localparam int T  = 16;
  localparam int WR = 3;
  localparam int WS = 1;
  localparam int NEVER = -1;
  localparam int EXT   = -2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic as = 1'b0;
  logic fn = 1'b0;
  logic slot_ack = 1'b0;
  logic [DEVICE_SELECTED_MAXPOS-1:0] dev = DEVICE_NULL;
  logic [PORT_WIDTH_WIDTH-1:0] pw = PORT_WIDTH_NULL;
  logic [1:0] dsack;
  logic berr;

  int checks = 0;
  int errors = 0;

  // Model: busy/done flags, edges since start, edge offset of termination
  bit m_busy = 0;
  bit m_done = 0;
  int m_n = 0;
  int m_ack_at = NEVER;
  logic [1:0] m_pw = PORT_WIDTH_NULL;
  logic [1:0] m_dsack = DSACK_NONE;
  logic m_berr = 1'b0;

  always #5 clock = ~clock;

  cycle_terminator #(
    .TIMEOUT_CYCLES(T),
    .WAIT_ROM(WR),
    .WAIT_SIMM(WS)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .as                       (as),
    .function_normal_selected (fn),
    .device_selected          (dev),
    .port_width               (pw),
    .slot_ack                 (slot_ack),
    .dsack                    (dsack),
    .berr                     (berr)
  );

  function automatic int wait_of(input logic [DEVICE_SELECTED_MAXPOS-1:0] d);
    if (d == DEVICE_ROM) return WR;
    if (d == DEVICE_SIMM) return WS;
    return 0;
  endfunction

  function automatic bit is_ext(input logic [DEVICE_SELECTED_MAXPOS-1:0] d);
    return (d == DEVICE_SLOT1) || (d == DEVICE_SLOT2) || (d == DEVICE_IDE) || (d == DEVICE_ETH);
  endfunction

  function automatic logic [DEVICE_SELECTED_MAXPOS-1:0] rand_dev();
    logic [DEVICE_SELECTED_MAXPOS-1:0] v;
    int r;
    v = '0;
    r = $urandom_range(0, DEVICE_SELECTED_MAXPOS);
    if (r < DEVICE_SELECTED_MAXPOS) v[r] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_dsack = DSACK_NONE; m_berr = 1'b0;
    end else if (!m_busy) begin
      if (as) begin
        m_busy = 1; m_n = 0; m_pw = pw; m_ack_at = NEVER;
        if (!fn) m_ack_at = NEVER;
        else if (dev == DEVICE_NULL) begin m_done = 1; m_berr = 1'b1; end
        else if (is_ext(dev)) m_ack_at = EXT;
        else m_ack_at = wait_of(dev) + 1;
      end
    end else if (m_done) begin
      if (!as) begin m_busy = 0; m_done = 0; m_dsack = DSACK_NONE; m_berr = 1'b0; end
    end else if (!as) begin
      m_busy = 0;
    end else begin
      m_n++;
      if ((m_ack_at == EXT && slot_ack) || m_n == m_ack_at) begin
        m_done = 1;
        if (m_pw == PORT_WIDTH_NULL) m_berr = 1'b1;
        else m_dsack = m_pw;
      end else if (m_n == T) begin
        m_done = 1; m_berr = 1'b1;
      end
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic f,
                                input logic [DEVICE_SELECTED_MAXPOS-1:0] d,
                                input logic [PORT_WIDTH_WIDTH-1:0] p, input logic s);
    as = a; fn = f; dev = d; pw = p; slot_ack = s;
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " dsack"}, 32'(dsack), 32'(m_dsack));
    check_output({tag, " berr"}, 32'(berr), 32'(m_berr));
    check_output({tag, " excl"}, 32'((dsack != DSACK_NONE) && berr), 32'(0));
  endtask

  initial begin
    logic [DEVICE_SELECTED_MAXPOS-1:0] d0;
    logic [PORT_WIDTH_WIDTH-1:0] p0;
    logic f0;
    int len;

    $display("[TB] start");
    reset_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_NULL, 1'b0);
    check_output("reset dsack", 32'(dsack), 32'(DSACK_NONE));
    check_output("reset berr", 32'(berr), 32'(0));
    check_output("reset state", 32'(dut.state), 32'(IDLE));
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_NULL, 1'b0);

    // ROM WORD, inputs changed after edge k must be ignored
    apply_stimulus(1'b1, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    check_output("rom k", 32'(dsack), 32'(DSACK_NONE));
    for (int i = 1; i <= 3; i++) begin
      apply_stimulus(1'b1, 1'b1, DEVICE_QUART, PORT_WIDTH_BYTE, 1'b0);
      check_output("rom wait", 32'(dsack), 32'(DSACK_NONE));
    end
    apply_stimulus(1'b1, 1'b0, DEVICE_NULL, PORT_WIDTH_LONG, 1'b0);
    check_output("rom ack k+4", 32'(dsack), 32'(DSACK_WORD));
    apply_stimulus(1'b1, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    check_output("rom hold", 32'(dsack), 32'(DSACK_WORD));
    apply_stimulus(1'b0, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    check_output("rom clear", 32'(dsack), 32'(DSACK_NONE));

    // QUART BYTE, zero wait states
    apply_stimulus(1'b1, 1'b1, DEVICE_QUART, PORT_WIDTH_BYTE, 1'b0);
    check_output("quart k", 32'(dsack), 32'(DSACK_NONE));
    apply_stimulus(1'b1, 1'b1, DEVICE_QUART, PORT_WIDTH_BYTE, 1'b0);
    check_output("quart k+1", 32'(dsack), 32'(DSACK_BYTE));
    apply_stimulus(1'b0, 1'b1, DEVICE_QUART, PORT_WIDTH_BYTE, 1'b0);

    // Unmapped normal cycle
    apply_stimulus(1'b1, 1'b1, DEVICE_NULL, PORT_WIDTH_WORD, 1'b0);
    apply_stimulus(1'b1, 1'b1, DEVICE_NULL, PORT_WIDTH_WORD, 1'b0);
    check_output("null berr", 32'(berr), 32'(1));
    check_output("null dsack", 32'(dsack), 32'(DSACK_NONE));
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_WORD, 1'b0);
    check_output("null clear", 32'(berr), 32'(0));

    // SLOT1 with no acknowledge: timeout at edge k+T
    apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    for (int i = 1; i < T; i++) apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    check_output("slot pre-timeout", 32'(berr), 32'(0));
    apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    check_output("slot timeout berr", 32'(berr), 32'(1));
    check_output("slot timeout dsack", 32'(dsack), 32'(DSACK_NONE));
    apply_stimulus(1'b0, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    check_output("slot timeout clear", 32'(berr), 32'(0));

    // SLOT1 acknowledged on the timeout edge: termination wins
    apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    for (int i = 1; i < T; i++) apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);
    apply_stimulus(1'b1, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b1);
    check_output("slot race dsack", 32'(dsack), 32'(DSACK_WORD));
    check_output("slot race berr", 32'(berr), 32'(0));
    apply_stimulus(1'b0, 1'b1, DEVICE_SLOT1, PORT_WIDTH_WORD, 1'b0);

    // SIMM LONG aborted after one cycle, then served normally
    apply_stimulus(1'b1, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    apply_stimulus(1'b0, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    apply_stimulus(1'b0, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    check_output("abort dsack", 32'(dsack), 32'(DSACK_NONE));
    check_output("abort berr", 32'(berr), 32'(0));
    apply_stimulus(1'b1, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    apply_stimulus(1'b1, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    check_output("simm k+1", 32'(dsack), 32'(DSACK_NONE));
    apply_stimulus(1'b1, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);
    check_output("simm k+2", 32'(dsack), 32'(DSACK_LONG));
    apply_stimulus(1'b0, 1'b1, DEVICE_SIMM, PORT_WIDTH_LONG, 1'b0);

    // Non-normal cycle: slot_ack ignored, only the watchdog ends it
    apply_stimulus(1'b1, 1'b0, DEVICE_SLOT2, PORT_WIDTH_LONG, 1'b1);
    for (int i = 1; i < T; i++) begin
      apply_stimulus(1'b1, 1'b0, DEVICE_SLOT2, PORT_WIDTH_LONG, 1'b1);
      check_output("fpu no dsack", 32'(dsack), 32'(DSACK_NONE));
    end
    apply_stimulus(1'b1, 1'b0, DEVICE_SLOT2, PORT_WIDTH_LONG, 1'b1);
    check_output("fpu timeout", 32'(berr), 32'(1));
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_NULL, 1'b0);

    // Zero-wait device with null port width ends in bus error
    apply_stimulus(1'b1, 1'b1, DEVICE_REGISTER16, PORT_WIDTH_NULL, 1'b0);
    apply_stimulus(1'b1, 1'b1, DEVICE_REGISTER16, PORT_WIDTH_NULL, 1'b0);
    check_output("pw null berr", 32'(berr), 32'(1));
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_NULL, 1'b0);

    // Reset during ACK of a ROM cycle
    for (int i = 0; i <= WR + 1; i++) apply_stimulus(1'b1, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    check_output("rst ack reached", 32'(dsack), 32'(DSACK_WORD));
    reset_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, DEVICE_ROM, PORT_WIDTH_WORD, 1'b0);
    check_output("rst dsack", 32'(dsack), 32'(DSACK_NONE));
    check_output("rst state", 32'(dut.state), 32'(IDLE));
    check_output("rst watchdog", 32'(dut.u_watchdog.count), 32'(0));
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, DEVICE_NULL, PORT_WIDTH_NULL, 1'b0);
    check_model("post reset");

    // Randomized cycles against the model
    for (int t = 0; t < 80; t++) begin
      d0 = rand_dev();
      p0 = 2'($urandom_range(0, 3));
      f0 = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, T + 3);
      for (int i = 0; i < len; i++) begin
        reset_n = ($urandom_range(0, 59) != 0);
        if (i == 0) apply_stimulus(1'b1, f0, d0, p0, ($urandom_range(0, 5) == 0));
        else apply_stimulus(1'b1, ($urandom_range(0, 7) != 0), rand_dev(),
                            2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        check_model("rand busy");
      end
      reset_n = 1'b1;
      for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
        apply_stimulus(1'b0, 1'b1, rand_dev(), 2'($urandom_range(0, 3)), 1'b0);
        check_model("rand idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
